// File: rtl/vga_pkg.sv
// Shared VGA geometry, direction/state enums and the per-axis range helper.
// Macro POINT_WRAP_EN selects wrap-around at the range bounds instead of clamping.
package vga_pkg;

  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;
  localparam int POINT_SIZE = 8;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    UPDATE
  } move_state_t;

  // Brings an 11-bit signed candidate position back into [lo, hi].
  function automatic logic [9:0] fit_axis(input logic signed [10:0] pos,
                                          input logic signed [10:0] lo,
                                          input logic signed [10:0] hi);
    logic [9:0] res;
    res = 10'(pos);
`ifdef POINT_WRAP_EN
    if (pos > hi)
      res = 10'(lo);
    else if (pos < lo)
      res = 10'(hi);
`else
    if (pos > hi)
      res = 10'(hi);
    else if (pos < lo)
      res = 10'(lo);
`endif
    return res;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Rising-edge detector on vblnk plus a frame divider; move_slot fires on the
// frame tick that closes each group of FRAME_DIV frames.
module frame_tick_gen #(
  parameter int FRAME_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic vblnk,
  output logic move_slot
);

  localparam logic [7:0] LAST = 8'(FRAME_DIV - 1);

  logic       vblnk_reg;
  logic [7:0] frame_cnt_reg;
  logic       frame_tick;

  assign frame_tick = vblnk & ~vblnk_reg;
  assign move_slot  = frame_tick && (frame_cnt_reg == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_reg     <= 1'b0;
      frame_cnt_reg <= 8'd0;
    end else begin
      vblnk_reg <= vblnk;
      if (frame_tick)
        frame_cnt_reg <= (frame_cnt_reg == LAST) ? 8'd0 : frame_cnt_reg + 8'd1;
    end
  end

endmodule

// File: rtl/point_move_ctrl.sv
// Buffers one move command and applies it to the point centre at the next
// move slot. Build with POINT_WRAP_EN to wrap at the bounds instead of clamping.
module point_move_ctrl
  import vga_pkg::*;
#(
  parameter logic [9:0] X_INIT    = 10'd600,
  parameter logic [9:0] Y_INIT    = 10'd300,
  parameter logic [9:0] STEP      = 10'd4,
  parameter int         FRAME_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblnk,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_dir,
  output logic       cmd_ready,
  output logic [9:0] point_x,
  output logic [9:0] point_y,
  output logic       moved
);

  localparam logic signed [10:0] X_MIN = 11'(POINT_SIZE - 1);
  localparam logic signed [10:0] X_MAX = 11'(HOR_PIXELS - 1 - POINT_SIZE);
  localparam logic signed [10:0] Y_MIN = 11'(POINT_SIZE - 1);
  localparam logic signed [10:0] Y_MAX = 11'(VER_PIXELS - 1 - POINT_SIZE);

  move_state_t state_reg, state_next;
  dir_t        dir_reg;
  logic [9:0]  point_x_reg, point_y_reg;
  logic [9:0]  x_next, y_next;
  logic signed [10:0] x_sum, y_sum, step_s;
  logic        move_slot;

  frame_tick_gen #(
    .FRAME_DIV(FRAME_DIV)
  ) u_frame_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .vblnk    (vblnk),
    .move_slot(move_slot)
  );

  assign point_x = point_x_reg;
  assign point_y = point_y_reg;

  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    moved      = 1'b0;
    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid)
          state_next = PENDING;
      end
      PENDING: begin
        // A slot seen while still IDLE never reaches here, so a command
        // accepted on a slot waits for the following one.
        if (move_slot)
          state_next = UPDATE;
      end
      UPDATE: begin
        moved      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    step_s = $signed({1'b0, STEP});
    x_sum  = $signed({1'b0, point_x_reg});
    y_sum  = $signed({1'b0, point_y_reg});
    case (dir_reg)
      UP:      y_sum = y_sum - step_s;
      DOWN:    y_sum = y_sum + step_s;
      LEFT:    x_sum = x_sum - step_s;
      RIGHT:   x_sum = x_sum + step_s;
      default: ;
    endcase
    x_next = fit_axis(x_sum, X_MIN, X_MAX);
    y_next = fit_axis(y_sum, Y_MIN, Y_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      dir_reg     <= UP;
      point_x_reg <= X_INIT;
      point_y_reg <= Y_INIT;
    end else begin
      state_reg <= state_next;
      if (cmd_valid && cmd_ready)
        dir_reg <= dir_t'(cmd_dir);
      if (state_reg == UPDATE) begin
        point_x_reg <= x_next;
        point_y_reg <= y_next;
      end
    end
  end

endmodule

// File: tb/tb_point_move_ctrl.sv
// Scoreboard bench: each accepted command pushes its expected before/after
// position; each moved pulse pops one entry and checks hold and update values.
module tb_point_move_ctrl;
  import vga_pkg::*;

  localparam int X_LO = POINT_SIZE - 1;
  localparam int X_HI = HOR_PIXELS - 1 - POINT_SIZE;
  localparam int Y_LO = POINT_SIZE - 1;
  localparam int Y_HI = VER_PIXELS - 1 - POINT_SIZE;
  localparam int STEP_I = 4;
`ifdef POINT_WRAP_EN
  localparam int EDGE_X = X_LO;
  localparam int EDGE_Y = Y_HI;
`else
  localparam int EDGE_X = X_HI;
  localparam int EDGE_Y = Y_LO;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vblnk = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_dir = 2'd0;
  logic       cmd_ready;
  logic [9:0] point_x, point_y;
  logic       moved;

  typedef struct {
    int ox;
    int oy;
    int nx;
    int ny;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur_exp;
  int   vec_count = 0;
  int   err_count = 0;
  int   moved_count = 0;
  int   acc_count = 0;
  int   mx = 600;
  int   my = 300;
  bit   chk_pending = 0;

  point_move_ctrl #(
    .X_INIT   (10'd600),
    .Y_INIT   (10'd300),
    .STEP     (10'd4),
    .FRAME_DIV(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .vblnk    (vblnk),
    .cmd_valid(cmd_valid),
    .cmd_dir  (cmd_dir),
    .cmd_ready(cmd_ready),
    .point_x  (point_x),
    .point_y  (point_y),
    .moved    (moved)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    vec_count++;
    if (got != exp) begin
      err_count++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_axis(input int v, input int lo, input int hi);
`ifdef POINT_WRAP_EN
    if (v > hi) return lo;
    if (v < lo) return hi;
`else
    if (v > hi) return hi;
    if (v < lo) return lo;
`endif
    return v;
  endfunction

  // Output monitor and scoreboard; sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      chk_pending = 0;
    end else begin
      if (chk_pending) begin
        check_val("upd_x", int'(point_x), cur_exp.nx);
        check_val("upd_y", int'(point_y), cur_exp.ny);
        $display("move %0d: x %0d->%0d y %0d->%0d", moved_count, cur_exp.ox,
                 int'(point_x), cur_exp.oy, int'(point_y));
        chk_pending = 0;
      end
      if (moved) begin
        moved_count++;
        if (sb_q.size() == 0) begin
          check_val("spurious_moved", 1, 0);
        end else begin
          cur_exp = sb_q.pop_front();
          check_val("hold_x", int'(point_x), cur_exp.ox);
          check_val("hold_y", int'(point_y), cur_exp.oy);
          chk_pending = 1;
        end
      end
      if (cmd_valid && cmd_ready) begin
        exp_t e;
        acc_count++;
        e.ox = mx;
        e.oy = my;
        case (cmd_dir)
          2'd0: my = model_axis(my - STEP_I, Y_LO, Y_HI);
          2'd1: my = model_axis(my + STEP_I, Y_LO, Y_HI);
          2'd2: mx = model_axis(mx - STEP_I, X_LO, X_HI);
          default: mx = model_axis(mx + STEP_I, X_LO, X_HI);
        endcase
        e.nx = mx;
        e.ny = my;
        sb_q.push_back(e);
      end
    end
  end

  task automatic apply_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    vblnk = 1'b0;
    sb_q.delete();
    mx = 600;
    my = 300;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic frame();
    vblnk = 1'b1;
    repeat (2) @(posedge clk);
    #1 vblnk = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  // Presents a command in the same cycle as the vblnk rising edge.
  task automatic frame_with_cmd(input logic [1:0] dir);
    vblnk = 1'b1;
    cmd_dir = dir;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    #1 vblnk = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] dir);
    bit ok;
    ok = 0;
    cmd_dir = dir;
    cmd_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check_val("accept_timeout", 0, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic do_move(input logic [1:0] dir);
    int m0;
    m0 = moved_count;
    send_cmd(dir);
    for (int f = 0; f < 4; f++) begin
      frame();
      if (moved_count != m0) break;
    end
    check_val("move_done", moved_count, m0 + 1);
  endtask

  initial begin
    int m0, a0;

    // Reset state and idle frames
    apply_reset();
    check_val("rst_x", int'(point_x), 600);
    check_val("rst_y", int'(point_y), 300);
    check_val("rst_ready", int'(cmd_ready), 1);
    check_val("rst_moved", int'(moved), 0);
    repeat (3) frame();
    check_val("idle_moved_cnt", moved_count, 0);
    check_val("idle_x", int'(point_x), 600);
    check_val("idle_y", int'(point_y), 300);
    check_val("idle_ready", int'(cmd_ready), 1);

    // RIGHT accepted mid frame 0, applied at end of frame 1
    apply_reset();
    m0 = moved_count;
    send_cmd(2'd3);
    check_val("r_ready_lo0", int'(cmd_ready), 0);
    frame();
    check_val("r_no_move_f0", moved_count, m0);
    check_val("r_ready_lo1", int'(cmd_ready), 0);
    frame();
    check_val("r_moved_f1", moved_count, m0 + 1);
    check_val("r_x", int'(point_x), 604);
    check_val("r_ready_hi", int'(cmd_ready), 1);

    // UP held valid while a LEFT is pending
    send_cmd(2'd2);
    a0 = acc_count;
    cmd_dir = 2'd0;
    cmd_valid = 1'b1;
    frame();
    check_val("up_stalled", acc_count, a0);
    check_val("up_ready_lo", int'(cmd_ready), 0);
    frame();
    cmd_valid = 1'b0;
    check_val("up_accepted", acc_count, a0 + 1);
    check_val("left_x", int'(point_x), 600);
    frame();
    frame();
    check_val("up_y", int'(point_y), 296);

    // Command accepted in the move_slot cycle waits a full slot period
    frame();
    m0 = moved_count;
    a0 = acc_count;
    frame_with_cmd(2'd1);
    check_val("slot_acc", acc_count, a0 + 1);
    check_val("slot_no_move", moved_count, m0);
    check_val("slot_ready_lo", int'(cmd_ready), 0);
    frame();
    check_val("slot_no_move2", moved_count, m0);
    frame();
    check_val("slot_moved", moved_count, m0 + 1);
    check_val("slot_y", int'(point_y), 300);

    // Bounds on x (right) and y (top)
    apply_reset();
    for (int i = 0; i < 49; i++) begin
      do_move(2'd3);
      if (i == 47) check_val("edge_x", int'(point_x), EDGE_X);
    end
    for (int i = 0; i < 75; i++) begin
      do_move(2'd0);
      if (i == 73) check_val("edge_y", int'(point_y), EDGE_Y);
    end

    // Reset while a LEFT is pending
    apply_reset();
    m0 = moved_count;
    send_cmd(2'd2);
    check_val("rp_pending", int'(cmd_ready), 0);
    frame();
    apply_reset();
    check_val("rp_x", int'(point_x), 600);
    check_val("rp_ready", int'(cmd_ready), 1);
    frame();
    frame();
    frame();
    check_val("rp_no_moved", moved_count, m0);
    check_val("rp_x_after", int'(point_x), 600);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/point_move_ctrl.md
POINT_MOVE_CTRL -- requirements
Module: point_move_ctrl

Interface
REQ-001 Parameter X_INIT, default 10'd600, reset x position of the point centre.
REQ-002 Parameter Y_INIT, default 10'd300, reset y position of the point centre.
REQ-003 Parameter STEP, default 10'd4, pixels moved per applied command.
REQ-004 Parameter FRAME_DIV, default 2, frames per move slot (range 1..255).
REQ-005 Clock and reset SHALL be: clk, input, 1, clock; rst, input, 1, reset, synchronous, active-high.
REQ-006 Ports SHALL be:
- vblnk, input, 1, vertical blank from the timing chain.
- cmd_valid, input, 1, move request valid.
- cmd_dir, input, 2, direction: 0 up, 1 down, 2 left, 3 right.
- cmd_ready, output, 1, pending buffer empty.
- point_x, output, 10, point centre x for the point overlay.
- point_y, output, 10, point centre y for the point overlay.
- moved, output, 1, one-cycle pulse when a position update is applied.

Function
REQ-007 frame_tick SHALL assert for one cycle on each rising edge of vblnk, using a registered copy of vblnk.
REQ-008 Frame counter SHALL count frame_ticks 0..FRAME_DIV-1 and wrap. move_slot SHALL be frame_tick with counter == FRAME_DIV-1.
REQ-009 A command SHALL be accepted when cmd_valid && cmd_ready. The accepted cmd_dir SHALL be stored in a one-entry buffer.
REQ-010 cmd_ready SHALL be high only in IDLE. Commands presented while the buffer is full SHALL stall; none SHALL be dropped.
REQ-011 FSM states and transitions:
- IDLE -> PENDING on accept.
- PENDING -> UPDATE on move_slot.
- UPDATE -> IDLE after one cycle.
REQ-012 A command accepted in the same cycle as move_slot SHALL wait for the next move_slot.
REQ-013 In UPDATE the position SHALL change by ±STEP on the stored axis. moved SHALL pulse in that cycle. The new value SHALL be visible on point_x/point_y the cycle after UPDATE.
REQ-014 Arithmetic SHALL use 11-bit signed intermediates so no 10-bit wrap occurs.
REQ-015 Legal centre range (without wrap feature):
- x: POINT_SIZE-1 .. HOR_PIXELS-1-POINT_SIZE.
- y: POINT_SIZE-1 .. VER_PIXELS-1-POINT_SIZE.
- Results outside the range SHALL clamp to the nearest bound.
REQ-016 A move at a bound toward that bound SHALL leave the position unchanged and still pulse moved.
REQ-017 point_x/point_y SHALL be registered and SHALL change only in the cycle following UPDATE.

Reset
REQ-018 On rst the block SHALL set:
- point_x=X_INIT, point_y=Y_INIT.
- state IDLE, buffer cleared.
- frame counter 0, vblnk copy 0.
- cmd_ready=1, moved=0.
REQ-019 rst asserted while in PENDING or UPDATE SHALL discard the pending command with no position change.

Configuration
REQ-020 With macro POINT_WRAP_EN defined, an out-of-range result SHALL wrap to the opposite bound instead of clamping.
REQ-021 Without POINT_WRAP_EN, clamping per REQ-015 SHALL apply. No wrap logic SHALL be synthesised.

Structure
REQ-022 HOR_PIXELS (800), VER_PIXELS (600), POINT_SIZE and a dir_t enum (UP, DOWN, LEFT, RIGHT) SHALL reside in vga_pkg.
REQ-023 A sub-module frame_tick_gen SHALL contain the vblnk edge detector and the FRAME_DIV counter, with move_slot as its output.
REQ-024 The FSM, buffer and position registers SHALL reside in point_move_ctrl.

Verification
REQ-025 Reset release with no command, 3 frames -> point_x=600, point_y=300, moved never high, cmd_ready=1.
REQ-026 FRAME_DIV=2, RIGHT accepted mid-frame 0 -> cmd_ready low until move_slot at end of frame 1; point_x=604 one cycle after the moved pulse.
REQ-027 Second command (UP) held valid while PENDING -> not accepted until IDLE; then applied at the next slot, point_y=296.
REQ-028 point_x=HOR_PIXELS-1-POINT_SIZE-2, RIGHT ->
- Without POINT_WRAP_EN: point_x=HOR_PIXELS-1-POINT_SIZE.
- With POINT_WRAP_EN: point_x=POINT_SIZE-1.
REQ-029 Command accepted in the same cycle as move_slot -> no update at that slot; update at the following slot.
REQ-030 rst pulsed while PENDING with LEFT stored -> point_x=600 after reset, no moved pulse, cmd_ready=1.
